// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder built around one full-add cell
// and a registered carry. An addition of WIDTH-bit operands takes WIDTH
// cycles in RUN followed by a one-cycle DONE pulse.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request to add a/b/cin, accepted in IDLE or DONE
//   a, b  - operands, sampled only on the accepting edge
//   cin   - carry-in, sampled only on the accepting edge
//   busy  - high while an addition is in progress
//   done  - one-cycle pulse, sum/cout valid from this cycle
//   sum   - result, held until the next completion
//   cout  - carry-out of the MSB, held with sum
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_c;
    logic             co_c;
    logic             last_c;
    logic             accept_c;

    // Full-add cell, accept decode and next-state logic
    always_comb begin
        state_nxt = state;
        s_c       = a_sr[0] ^ b_sr[0] ^ carry;
        co_c      = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last_c    = (cnt == CNT_LAST);
        accept_c  = start && ((state == S_IDLE) || (state == S_DONE));

        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
            if (accept_c) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                // Sum bits enter at the MSB so bit i settles at position i
                carry  <= co_c;
                res_sr <= {s_c, res_sr[WIDTH-1:1]};
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                cnt    <= cnt + CW'(1);
                if (last_c) begin
                    sum  <= {s_c, res_sr[WIDTH-1:1]};
                    cout <= co_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): the driver pushes expected
// {cout,sum} per accepted add; a monitor pops and compares on every done.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] sb[$];
    logic [W:0] exp_held;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare results on done, and check outputs hold while busy
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_held = sb.pop_front();
                    check("sum", 32'(sum), 32'(exp_held[W-1:0]));
                    check("cout", 32'(cout), 32'(exp_held[W]));
                end
            end else if (busy) begin
                check("held_result", 32'({cout, sum}), 32'(exp_held));
            end
        end
    end

    // Accept one add, optionally poke start mid-run, check busy/done timing
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input logic [W-1:0] es, input logic ec, input int poke);
        a     = oa;
        b     = ob;
        cin   = oc;
        start = 1'b1;
        sb.push_back({ec, es});
        tick();
        start = 1'b0;
        a     = ~oa;
        b     = 8'h5A;
        cin   = ~oc;
        for (int i = 1; i <= int'(W); i++) begin
            check("busy_run", 32'(busy), 32'(1));
            check("done_run", 32'(done), 32'(0));
            if (i == poke) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("done_pulse", 32'(done), 32'(1));
        check("busy_done", 32'(busy), 32'(0));
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_done"}, 32'(done), 32'(0));
        check({name, "_sum"}, 32'(sum), 32'(0));
        check({name, "_cout"}, 32'(cout), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_held = '0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // 1: basic add
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);
        tick();
        check("idle_after_done", 32'(done), 32'(0));

        // 2: overflow cases
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
        tick();

        // 3: start during RUN is ignored
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
        tick();
        check("ignored_start_no_rerun", 32'(busy), 32'(0));

        // 4: reset mid-run abandons the add
        a     = 8'h33;
        b     = 8'h44;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        exp_held = '0;
        tick();
        rst = 1'b0;
        check_idle("midrun_reset");
        for (int i = 0; i < 12; i++) begin
            check("no_done_after_reset", 32'(done), 32'(0));
            tick();
        end
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        // 5: back-to-back from the DONE cycle
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1);
        tick();

        // 6: start and reset together, reset wins
        a     = 8'hC3;
        b     = 8'h3C;
        start = 1'b1;
        rst   = 1'b1;
        sb.delete();
        exp_held = '0;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_idle("start_with_reset");
        for (int i = 0; i < 10; i++) begin
            check("stay_idle", 32'(busy | done), 32'(0));
            tick();
        end

        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
